// File: rtl/gelu_tanh_arg.sv
// gelu_tanh_arg: pipelined u = sqrt(2/pi)*(x + 0.044715*x^3) feeder for the GELU tanh stage,
// with valid/ready backpressure and a DEPTH-element frame marker.
module gelu_tanh_arg #(
    parameter int DW    = 8,
    parameter int FRAC  = 4,
    parameter int DEPTH = 4,
    parameter int K3    = 2930,
    parameter int KC    = 52290
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   i_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] o_u,
    output logic            o_last
);
    localparam int PW = 3*DW + 18;
    localparam int QW = PW + 18;
    localparam int SH = 16 + 2*FRAC;
    localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic signed [PW-1:0] K3W  = PW'(K3);
    localparam logic signed [QW-1:0] KCW  = QW'(KC);
    localparam logic signed [QW-1:0] UMAX = {{(QW-2*DW+1){1'b0}}, {(2*DW-1){1'b1}}};
    localparam logic signed [QW-1:0] UMIN = ~UMAX;

    logic                   v1, v2, v3, v4;
    logic                   ld1, ld2, ld3, ld4;
    logic signed [DW-1:0]   s1_x, s2_x;
    logic signed [2*DW-1:0] s1_x2;
    logic signed [3*DW-1:0] s2_x3;
    logic signed [PW-1:0]   s3_t, p3;
    logic signed [QW-1:0]   p4, q;
    logic [2*DW-1:0]        u_sat;
    logic [CW-1:0]          cnt;

    // A stage may load when empty or when the stage after it drains this cycle.
    always_comb begin
        ld4      = ~v4 | out_ready;
        ld3      = ~v3 | ld4;
        ld2      = ~v2 | ld3;
        ld1      = ~v1 | ld2;
        in_ready = rstn & en & ld1;
        p3       = PW'(s2_x3) * K3W;
        p4       = QW'(s3_t) * KCW;
        q        = p4 >>> 16;
        u_sat    = q > UMAX ? UMAX[2*DW-1:0] : (q < UMIN ? UMIN[2*DW-1:0] : q[2*DW-1:0]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {v1, v2, v3, v4} <= '0;
            s1_x  <= '0;
            s1_x2 <= '0;
            s2_x  <= '0;
            s2_x3 <= '0;
            s3_t  <= '0;
            o_u   <= '0;
            cnt   <= '0;
        end else if (!en) begin
            {v1, v2, v3, v4} <= '0;
            cnt <= '0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld1 && in_valid) begin
                s1_x  <= $signed(i_x);
                s1_x2 <= (2*DW)'($signed(i_x)) * (2*DW)'($signed(i_x));
            end
            if (ld2) v2 <= v1;
            if (ld2 && v1) begin
                s2_x  <= s1_x;
                s2_x3 <= (3*DW)'(s1_x2) * (3*DW)'(s1_x);
            end
            if (ld3) v3 <= v2;
            if (ld3 && v2) s3_t <= PW'(s2_x) + (p3 >>> SH);
            if (ld4) v4 <= v3;
            if (ld4 && v3) o_u <= u_sat;
            if (v4 && out_ready) cnt <= cnt == CW'(DEPTH-1) ? '0 : cnt + CW'(1);
        end
    end

    assign out_valid = v4;
    assign o_last    = v4 & (cnt == CW'(DEPTH-1));
endmodule

// File: tb/tb_gelu_tanh_arg.sv
// tb_gelu_tanh_arg: directed and randomized checks of the GELU tanh-argument pipeline
// against hand-computed values and an integer model of the formula.
module tb_gelu_tanh_arg;
    logic        clk = 1'b0;
    logic        rstn, en, in_valid, in_ready, out_valid, out_ready, o_last;
    logic [7:0]  i_x;
    logic [15:0] o_u;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        ir_s, ov_s, ol_s;
    logic [15:0] ou_s;

    always #5 clk = ~clk;

    gelu_tanh_arg #(.DW(8), .FRAC(4), .DEPTH(4), .K3(2930), .KC(52290)) dut (
        .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .i_x(i_x), .out_valid(out_valid), .out_ready(out_ready), .o_u(o_u), .o_last(o_last)
    );

    function automatic int ref_u(int x);
        longint x3 = longint'(x) * x * x;
        longint t  = longint'(x) + ((x3 * 2930) >>> 24);
        longint u  = (t * 52290) >>> 16;
        if (u > 32767) u = 32767;
        if (u < -32768) u = -32768;
        return int'(u);
    endfunction

    // Sample pre-edge values mid-cycle, then advance to just after the next rising edge.
    task automatic step();
        #3;
        ir_s = in_ready;
        ov_s = out_valid;
        ol_s = o_last;
        ou_s = o_u;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_en();
        en = 1'b0;
        in_valid = 1'b0;
        step();
        n_checks++;
        if (ir_s !== 1'b0) begin n_fail++; $display("FAIL en_low_ready got=%b want=0", ir_s); end
        en = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1; i_x = 8'd16;
        #2;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++;
        if (o_u !== 16'h0) begin n_fail++; $display("FAIL reset_o_u got=%h want=0000", o_u); end
        n_checks++;
        if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_o_last got=%b want=0", o_last); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        int vals[4]  = '{16, 32, -32, 127};
        int exp_u[4] = '{12, 29, -31, 386};
        int got = 0;
        int gv;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 4);
            i_x = 8'h0;
            if (c < 4) i_x = 8'(vals[c]);
            out_ready = 1'b1;
            step();
            if (c < 4) begin
                n_checks++;
                if (ir_s !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready c=%0d got=%b want=1", c, ir_s); end
            end
            if (ov_s === 1'b1) begin
                gv = $signed(ou_s);
                n_checks++;
                if (got >= 4) begin
                    n_fail++; $display("FAIL basic_extra got=%0d outputs want=4", got + 1);
                end else begin
                    if (c != 4 + got) begin n_fail++; $display("FAIL basic_cycle got=%0d want=%0d", c, 4 + got); end
                    n_checks++;
                    if (gv !== exp_u[got]) begin n_fail++; $display("FAIL basic_o_u got=%0d want=%0d", gv, exp_u[got]); end
                    n_checks++;
                    if (ol_s !== (got == 3)) begin n_fail++; $display("FAIL basic_o_last got=%b want=%b", ol_s, got == 3); end
                end
                got++;
            end
        end
        n_checks++;
        if (got != 4) begin n_fail++; $display("FAIL basic_count got=%0d want=4", got); end
    endtask

    task automatic test_neg_zero();
        int vals[2]  = '{-128, 0};
        int exp_u[2] = '{-395, 0};
        int got = 0;
        int gv;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 2);
            i_x = 8'h0;
            if (c < 2) i_x = 8'(vals[c]);
            out_ready = 1'b1;
            step();
            if (ov_s === 1'b1 && got < 2) begin
                gv = $signed(ou_s);
                n_checks++;
                if (gv !== exp_u[got]) begin n_fail++; $display("FAIL negzero_o_u got=%0d want=%0d", gv, exp_u[got]); end
                n_checks++;
                if (ol_s !== 1'b0) begin n_fail++; $display("FAIL negzero_o_last got=%b want=0", ol_s); end
                got++;
            end
        end
        n_checks++;
        if (got != 2) begin n_fail++; $display("FAIL negzero_count got=%0d want=2", got); end
    endtask

    task automatic test_stall();
        int vals[8] = '{16, 32, -32, 127, -128, 0, 1, -1};
        int ni = 0, no = 0, occ = 0, full_seen = 0;
        int gv;
        logic prev_stall = 1'b0;
        logic [15:0] prev_u = '0;
        logic prev_l = 1'b0;
        logic acc;
        pulse_en();
        for (int c = 0; c < 80 && no < 8; c++) begin
            in_valid = (ni < 8);
            i_x = 8'h0;
            if (ni < 8) i_x = 8'(vals[ni]);
            out_ready = (c % 3 == 0);
            step();
            n_checks++;
            if (ir_s !== !(occ == 4 && !out_ready)) begin
                n_fail++; $display("FAIL stall_in_ready c=%0d occ=%0d got=%b", c, occ, ir_s);
            end
            if (occ == 4 && !out_ready) full_seen++;
            if (prev_stall) begin
                n_checks++;
                if (ov_s !== 1'b1 || ou_s !== prev_u || ol_s !== prev_l) begin
                    n_fail++; $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b", ov_s, ou_s, ol_s, prev_u, prev_l);
                end
            end
            if (ov_s === 1'b1 && out_ready) begin
                gv = $signed(ou_s);
                n_checks++;
                if (gv !== ref_u(vals[no])) begin n_fail++; $display("FAIL stall_o_u #%0d got=%0d want=%0d", no, gv, ref_u(vals[no])); end
                n_checks++;
                if (ol_s !== (no % 4 == 3)) begin n_fail++; $display("FAIL stall_o_last #%0d got=%b want=%b", no, ol_s, no % 4 == 3); end
                no++;
            end
            acc = in_valid && ir_s;
            if (acc) ni++;
            occ = occ + int'(acc) - int'(ov_s === 1'b1 && out_ready);
            prev_stall = (ov_s === 1'b1) && !out_ready;
            prev_u = ou_s;
            prev_l = ol_s;
        end
        n_checks++;
        if (no != 8) begin n_fail++; $display("FAIL stall_count got=%0d want=8", no); end
        n_checks++;
        if (full_seen == 0) begin n_fail++; $display("FAIL stall_full_seen got=0 want>0"); end
        out_ready = 1'b1;
    endtask

    task automatic test_enable();
        int pre[2]   = '{1, -1};
        int vals[4]  = '{16, 32, -32, 127};
        int exp_u[4] = '{12, 29, -31, 386};
        int got = 0;
        int gv;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            i_x = 8'(pre[c]);
            step();
        end
        en = 1'b0;
        in_valid = 1'b1;
        step();
        n_checks++;
        if (ir_s !== 1'b0) begin n_fail++; $display("FAIL enable_in_ready got=%b want=0", ir_s); end
        en = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 4);
            i_x = 8'h0;
            if (c < 4) i_x = 8'(vals[c]);
            step();
            if (ov_s === 1'b1) begin
                gv = $signed(ou_s);
                n_checks++;
                if (got >= 4) begin
                    n_fail++; $display("FAIL enable_extra got=%0d outputs want=4", got + 1);
                end else begin
                    if (gv !== exp_u[got]) begin n_fail++; $display("FAIL enable_o_u got=%0d want=%0d", gv, exp_u[got]); end
                    n_checks++;
                    if (ol_s !== (got == 3)) begin n_fail++; $display("FAIL enable_o_last got=%b want=%b", ol_s, got == 3); end
                end
                got++;
            end
        end
        n_checks++;
        if (got != 4) begin n_fail++; $display("FAIL enable_count got=%0d want=4", got); end
    endtask

    task automatic test_async_reset();
        int pre[3]  = '{64, -64, 100};
        int vals[4] = '{1, -1, 64, -64};
        int got = 0;
        int gv;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            i_x = 8'(pre[c]);
            step();
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid got=%b want=1", out_valid); end
        #1;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got=%b want=0", out_valid); end
        n_checks++;
        if (o_u !== 16'h0) begin n_fail++; $display("FAIL arst_o_u got=%h want=0000", o_u); end
        n_checks++;
        if (o_last !== 1'b0) begin n_fail++; $display("FAIL arst_o_last got=%b want=0", o_last); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready got=%b want=0", in_ready); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 4);
            i_x = 8'h0;
            if (c < 4) i_x = 8'(vals[c]);
            step();
            if (ov_s === 1'b1) begin
                gv = $signed(ou_s);
                n_checks++;
                if (got >= 4) begin
                    n_fail++; $display("FAIL arst_extra got=%0d outputs want=4", got + 1);
                end else begin
                    if (gv !== ref_u(vals[got])) begin n_fail++; $display("FAIL arst_o_u got=%0d want=%0d", gv, ref_u(vals[got])); end
                    n_checks++;
                    if (ol_s !== (got == 3)) begin n_fail++; $display("FAIL arst_o_last got=%b want=%b", ol_s, got == 3); end
                end
                got++;
            end
        end
        n_checks++;
        if (got != 4) begin n_fail++; $display("FAIL arst_count got=%0d want=4", got); end
    endtask

    task automatic test_random();
        int q[$];
        int ni = 0, no = 0, occ = 0, lasts = 0;
        int gv, xv, ev;
        logic prev_stall = 1'b0;
        logic [15:0] prev_u = '0;
        logic prev_l = 1'b0;
        logic acc;
        logic [7:0] nx;
        nx = 8'($urandom_range(0, 255));
        for (int c = 0; c < 8000 && no < 1000; c++) begin
            in_valid = (ni < 1000) && ($urandom_range(0, 9) < 7);
            i_x = nx;
            out_ready = ($urandom_range(0, 9) < 7) || (ni >= 1000);
            step();
            n_checks++;
            if (ir_s !== !(occ == 4 && !out_ready)) begin
                n_fail++; $display("FAIL rand_in_ready c=%0d occ=%0d got=%b", c, occ, ir_s);
            end
            if (prev_stall) begin
                n_checks++;
                if (ov_s !== 1'b1 || ou_s !== prev_u || ol_s !== prev_l) begin
                    n_fail++; $display("FAIL rand_hold got=%b/%h/%b want=1/%h/%b", ov_s, ou_s, ol_s, prev_u, prev_l);
                end
            end
            if (ov_s === 1'b1 && out_ready) begin
                gv = $signed(ou_s);
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious got=%0d want=none", gv);
                end else begin
                    ev = ref_u(q.pop_front());
                    if (gv !== ev) begin n_fail++; $display("FAIL rand_o_u #%0d got=%0d want=%0d", no, gv, ev); end
                end
                n_checks++;
                if (ol_s !== (no % 4 == 3)) begin n_fail++; $display("FAIL rand_o_last #%0d got=%b want=%b", no, ol_s, no % 4 == 3); end
                if (ol_s === 1'b1) lasts++;
                no++;
            end
            acc = in_valid && ir_s;
            if (acc) begin
                xv = $signed(nx);
                q.push_back(xv);
                ni++;
                nx = 8'($urandom_range(0, 255));
            end
            occ = occ + int'(acc) - int'(ov_s === 1'b1 && out_ready);
            prev_stall = (ov_s === 1'b1) && !out_ready;
            prev_u = ou_s;
            prev_l = ol_s;
        end
        n_checks++;
        if (no != 1000) begin n_fail++; $display("FAIL rand_count got=%0d want=1000", no); end
        n_checks++;
        if (lasts != no / 4) begin n_fail++; $display("FAIL rand_last_count got=%0d want=%0d", lasts, no / 4); end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_zero();
        test_stall();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gelu_tanh_arg.md
Name: gelu_tanh_arg

Overview:
- Upstream feeder for the tanh stage in the GELU activation path: u = sqrt(2/pi)*(x + 0.044715*x^3).
- Consumes signed att-width activations from the attention/MLP datapath and emits signed double-width arguments for the tanh unit.
- Fully pipelined with valid/ready backpressure and a frame counter that marks every DEPTH-th result, matching the tanh stage's DEPTH-element batches.

Parameters:
- DW, 8, input width; signed two's complement.
- FRAC, 4, fractional bits of both input and output.
- DEPTH, 4, elements per frame; o_last marks the final element of each frame.
- K3, 2930, round(0.044715*2^16), unsigned Q0.16 constant.
- KC, 52290, round(sqrt(2/pi)*2^16), unsigned Q0.16 constant.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  block enable; low flushes the pipeline and the frame counter.
- in_valid  input  1  i_x valid.
- in_ready  output  1  stage 1 can accept this cycle.
- i_x  input  DW  signed activation, FRAC fractional bits.
- out_valid  output  1  o_u valid.
- out_ready  input  1  downstream (tanh) accepts.
- o_u  output  2*DW  signed argument, FRAC fractional bits.
- o_last  output  1  high with the DEPTH-th element of a frame.

Behaviour:
- Reset (rstn=0, async): all stage valids=0, data regs=0, frame count=0. Outputs: out_valid=0, o_u=0, o_last=0. in_ready=0 while rstn=0.
- Pipeline, 4 register stages; each holds valid plus data.
  - S1: x, x2=x*x (2*DW bits, 2*FRAC frac).
  - S2: x, x3=x2*x (3*DW bits, 3*FRAC frac).
  - S3: t = sign-extended x + (x3*K3 >>> (16+2*FRAC)).
  - S4: u = (t*KC) >>> 16, saturated to the signed 2*DW range.
- Shifts are arithmetic, so they floor toward minus infinity. Intermediates are wide enough that no overflow occurs before saturation.
- Stage k loads when its own valid=0 or stage k+1 loads in the same cycle. Stage 4 empties when out_ready=1.
- in_ready = en & (~v1 | stage-2 load). Input transfer = in_valid & in_ready.
- Latency: 4 cycles from input transfer to out_valid with no stall. Throughput: 1 element/cycle.
- Stall: out_valid=1 & out_ready=0 holds o_u and o_last stable. Bubbles compress upstream; no data is lost or duplicated.
- Frame counter 0..DEPTH-1 increments on each output transfer.
  - o_last = out_valid & (count==DEPTH-1).
  - On transfer at DEPTH-1, the counter wraps to 0.
- en=0 (synchronous): all valids cleared and count=0 at the next edge, in_ready=0. Data regs keep their value. Resuming en=1 starts a fresh frame.
- rstn asserted mid-frame: immediate clear; no partial frame survives.
- Simultaneous in_valid with a full, stalled pipe: in_ready=0; upstream holds i_x.

Test Plan:
- DW=8, FRAC=4, out_ready=1, inputs 16, 32, -32, 127 back-to-back -> o_u = 12, 29, -31, 386 on 4 consecutive cycles starting 4 cycles after the first transfer. o_last=1 only with 386.
- Input -128 then 0 -> o_u = -395 then 0. Confirms floor rounding of the negative cubic term and a zero-in/zero-out path.
- Stream 8 values with out_ready toggling 1,0,0,1,... -> outputs in order with no drop or duplicate, o_u stable while stalled, o_last on output #4 and #8, in_ready=0 whenever all 4 stages hold data and out_ready=0.
- Feed 2 elements, then drop en for 1 cycle, then feed 16, 32, -32, 127 -> pre-drop data never emerges, in_ready=0 during en=0, o_last asserts with 127, i.e. the counter restarted.
- Pulse rstn low mid-stream with 3 stages full -> out_valid, o_u and o_last read 0 immediately (async). After release, the next 4 inputs form a complete frame with o_last on the 4th.
- Random signed DW-bit stream of 1000 values with random in_valid/out_ready -> every o_u matches a bit-exact reference model of the formulas above, and the o_last count equals floor(outputs/DEPTH).
